// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline and long-latency results onto the single
// register-file write port, buffering long-latency results and tracking pending writes.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            stall_i,
  input  logic            pipe_wr_i,
  input  logic [4:0]      pipe_addr_i,
  input  logic [XLEN-1:0] pipe_data_i,
  input  logic            issue_i,
  input  logic [4:0]      issue_addr_i,
  input  logic            lu_valid_i,
  output logic            lu_ready_o,
  input  logic [4:0]      lu_addr_i,
  input  logic [XLEN-1:0] lu_data_i,
  input  logic [4:0]      rdaddra_i,
  input  logic [4:0]      rdaddrb_i,
  input  logic [4:0]      rdaddrc_i,
  output logic [2:0]      raw_hazard_o,
  output logic            waw_hazard_o,
  output logic            wr_o,
  output logic [4:0]      wraddr_o,
  output logic [XLEN-1:0] wrdata_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [4:0]      addr_mem_q [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     pend_q, pend_d;
  logic            wr_q, wr_d;
  logic [4:0]      wraddr_q, wraddr_d;
  logic [XLEN-1:0] wrdata_q, wrdata_d;

  logic            pipe_sel;
  logic            fifo_pop;
  logic            fifo_push;
  logic            lu_accept;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;

  // Ready comes only from the registered count so pops never reach lu_ready_o.
  assign lu_ready_o = (cnt_q != CW'(DEPTH));
  assign lu_accept  = lu_valid_i && lu_ready_o;
  assign fifo_push  = lu_accept && (lu_addr_i != 5'd0);
  assign pipe_sel   = !stall_i && pipe_wr_i && (pipe_addr_i != 5'd0);
  assign fifo_pop   = !pipe_sel && (cnt_q != '0);
  assign head_addr  = addr_mem_q[rptr_q];
  assign head_data  = data_mem_q[rptr_q];

  assign raw_hazard_o = {pend_q[rdaddrc_i], pend_q[rdaddrb_i], pend_q[rdaddra_i]};
  assign waw_hazard_o = pipe_wr_i && pend_q[pipe_addr_i];

  assign wr_o     = wr_q;
  assign wraddr_o = wraddr_q;
  assign wrdata_o = wrdata_q;

  always_comb begin
    wr_d     = 1'b0;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q + CW'(fifo_push) - CW'(fifo_pop);
    pend_d   = pend_q;

    if (pipe_sel) begin
      wr_d     = 1'b1;
      wraddr_d = pipe_addr_i;
      wrdata_d = pipe_data_i;
    end else if (fifo_pop) begin
      wr_d     = 1'b1;
      wraddr_d = head_addr;
      wrdata_d = head_data;
      rptr_d   = rptr_q + AW'(1);
      pend_d[head_addr] = 1'b0;
    end

    if (fifo_push) begin
      wptr_d = wptr_q + AW'(1);
    end

    // Set is applied after clear so a same-cycle re-issue stays pending.
    if (issue_i && !stall_i && (issue_addr_i != 5'd0)) begin
      pend_d[issue_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q     <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
    end else begin
      wr_q     <= wr_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      addr_mem_q[wptr_q] <= lu_addr_i;
      data_mem_q[wptr_q] <= lu_data_i;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: hand-computed expectations for each writeback scenario.
module tb_wb_arbiter;

  logic        clk_i;
  logic        reset_i;
  logic        stall_i;
  logic        pipe_wr_i;
  logic [4:0]  pipe_addr_i;
  logic [31:0] pipe_data_i;
  logic        issue_i;
  logic [4:0]  issue_addr_i;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  lu_addr_i;
  logic [31:0] lu_data_i;
  logic [4:0]  rdaddra_i;
  logic [4:0]  rdaddrb_i;
  logic [4:0]  rdaddrc_i;
  logic [2:0]  raw_hazard_o;
  logic        waw_hazard_o;
  logic        wr_o;
  logic [4:0]  wraddr_o;
  logic [31:0] wrdata_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .stall_i      (stall_i),
    .pipe_wr_i    (pipe_wr_i),
    .pipe_addr_i  (pipe_addr_i),
    .pipe_data_i  (pipe_data_i),
    .issue_i      (issue_i),
    .issue_addr_i (issue_addr_i),
    .lu_valid_i   (lu_valid_i),
    .lu_ready_o   (lu_ready_o),
    .lu_addr_i    (lu_addr_i),
    .lu_data_i    (lu_data_i),
    .rdaddra_i    (rdaddra_i),
    .rdaddrb_i    (rdaddrb_i),
    .rdaddrc_i    (rdaddrc_i),
    .raw_hazard_o (raw_hazard_o),
    .waw_hazard_o (waw_hazard_o),
    .wr_o         (wr_o),
    .wraddr_o     (wraddr_o),
    .wrdata_o     (wrdata_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wr"}, {31'd0, wr_o}, {31'd0, w});
    chk({tag, "_addr"}, {27'd0, wraddr_o}, {27'd0, a});
    chk({tag, "_data"}, wrdata_o, d);
  endtask

  // Issues only to a register the bench has just seen as not pending.
  task automatic issue(input logic [4:0] a);
    rdaddra_i = a;
    #1;
    chk("pre_issue_free", {31'd0, raw_hazard_o[0]}, 32'd0);
    issue_i      = 1'b1;
    issue_addr_i = a;
    step();
    issue_i   = 1'b0;
    rdaddra_i = 5'd0;
  endtask

  initial begin
    reset_i = 1'b1; stall_i = 1'b0;
    pipe_wr_i = 1'b0; pipe_addr_i = '0; pipe_data_i = '0;
    issue_i = 1'b0; issue_addr_i = '0;
    lu_valid_i = 1'b0; lu_addr_i = '0; lu_data_i = '0;
    rdaddra_i = '0; rdaddrb_i = '0; rdaddrc_i = '0;

    // Reset state
    #2;
    chk_wr("rst", 1'b0, 5'd0, 32'd0);
    chk("rst_ready", {31'd0, lu_ready_o}, 32'd1);
    chk("rst_raw", {29'd0, raw_hazard_o}, 32'd0);
    step(); step();
    reset_i = 1'b0;

    // Plain pipeline write, then hold of address/data when idle
    pipe_wr_i = 1'b1; pipe_addr_i = 5'd5; pipe_data_i = 32'hDEADBEEF;
    #1;
    chk("waw_idle", {31'd0, waw_hazard_o}, 32'd0);
    step();
    chk_wr("pipe_x5", 1'b1, 5'd5, 32'hDEADBEEF);
    pipe_wr_i = 1'b0;
    step();
    chk_wr("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF);

    // Scoreboard RAW/WAW and long-latency return
    issue(5'd7);
    rdaddrb_i = 5'd7;
    #1;
    chk("raw_x7", {29'd0, raw_hazard_o}, 32'b010);
    pipe_wr_i = 1'b1; pipe_addr_i = 5'd7;
    #1;
    chk("waw_x7", {31'd0, waw_hazard_o}, 32'd1);
    pipe_wr_i = 1'b0;
    lu_valid_i = 1'b1; lu_addr_i = 5'd7; lu_data_i = 32'h1234;
    #1;
    chk("lu_ready_x7", {31'd0, lu_ready_o}, 32'd1);
    step();
    lu_valid_i = 1'b0;
    chk("x7_not_yet", {31'd0, wr_o}, 32'd0);
    chk("raw_x7_still", {29'd0, raw_hazard_o}, 32'b010);
    step();
    chk_wr("lu_x7", 1'b1, 5'd7, 32'h1234);
    chk("raw_x7_clear", {29'd0, raw_hazard_o}, 32'd0);
    rdaddrb_i = 5'd0;

    // Fill the FIFO behind continuous pipeline writes, then drain in order
    pipe_wr_i = 1'b1; pipe_addr_i = 5'd1; pipe_data_i = 32'h11;
    lu_valid_i = 1'b1; lu_addr_i = 5'd10; lu_data_i = 32'hA0;
    step();
    chk_wr("fill_p1", 1'b1, 5'd1, 32'h11);
    chk("fill_ready1", {31'd0, lu_ready_o}, 32'd1);
    pipe_addr_i = 5'd2; pipe_data_i = 32'h22;
    lu_addr_i = 5'd11; lu_data_i = 32'hB1;
    step();
    chk_wr("fill_p2", 1'b1, 5'd2, 32'h22);
    chk("fill_full", {31'd0, lu_ready_o}, 32'd0);
    pipe_addr_i = 5'd3; pipe_data_i = 32'h33;
    lu_addr_i = 5'd12; lu_data_i = 32'hC2;
    step();
    chk_wr("fill_p3", 1'b1, 5'd3, 32'h33);
    chk("fill_blocked", {31'd0, lu_ready_o}, 32'd0);
    pipe_wr_i = 1'b0;
    step();
    chk_wr("drain_x10", 1'b1, 5'd10, 32'hA0);
    chk("drain_ready", {31'd0, lu_ready_o}, 32'd1);
    step();
    lu_valid_i = 1'b0;
    chk_wr("drain_x11", 1'b1, 5'd11, 32'hB1);
    step();
    chk_wr("drain_x12", 1'b1, 5'd12, 32'hC2);
    step();
    chk("drain_done", {31'd0, wr_o}, 32'd0);
    chk("drain_ready_end", {31'd0, lu_ready_o}, 32'd1);

    // Stall blocks the pipe side and issue, but the FIFO still pops
    lu_valid_i = 1'b1; lu_addr_i = 5'd13; lu_data_i = 32'hD3;
    step();
    lu_valid_i = 1'b0;
    chk("stall_pre", {31'd0, wr_o}, 32'd0);
    stall_i = 1'b1;
    pipe_wr_i = 1'b1; pipe_addr_i = 5'd4; pipe_data_i = 32'h44;
    issue_i = 1'b1; issue_addr_i = 5'd9;
    step();
    issue_i = 1'b0;
    chk_wr("stall_fifo", 1'b1, 5'd13, 32'hD3);
    rdaddrc_i = 5'd9;
    #1;
    chk("stall_no_issue", {29'd0, raw_hazard_o}, 32'd0);
    rdaddrc_i = 5'd0;
    stall_i = 1'b0;
    step();
    chk_wr("unstall_pipe", 1'b1, 5'd4, 32'h44);
    pipe_wr_i = 1'b0;

    // Writes to x0 from either source are dropped
    pipe_wr_i = 1'b1; pipe_addr_i = 5'd0; pipe_data_i = 32'h66;
    lu_valid_i = 1'b1; lu_addr_i = 5'd0; lu_data_i = 32'h55;
    #1;
    chk("x0_ready", {31'd0, lu_ready_o}, 32'd1);
    step();
    pipe_wr_i = 1'b0; lu_valid_i = 1'b0;
    chk("x0_no_wr", {31'd0, wr_o}, 32'd0);
    chk("x0_ready_after", {31'd0, lu_ready_o}, 32'd1);
    step();
    chk("x0_not_stored", {31'd0, wr_o}, 32'd0);

    // Asynchronous reset with full FIFO and three pending registers
    issue(5'd20);
    issue(5'd21);
    issue(5'd22);
    pipe_wr_i = 1'b1; pipe_addr_i = 5'd1; pipe_data_i = 32'h77;
    lu_valid_i = 1'b1; lu_addr_i = 5'd20; lu_data_i = 32'h200;
    step();
    lu_addr_i = 5'd21; lu_data_i = 32'h210;
    step();
    lu_valid_i = 1'b0;
    rdaddra_i = 5'd20; rdaddrb_i = 5'd21; rdaddrc_i = 5'd22;
    #1;
    chk("pre_rst_full", {31'd0, lu_ready_o}, 32'd0);
    chk("pre_rst_raw", {29'd0, raw_hazard_o}, 32'b111);
    chk("pre_rst_wr", {31'd0, wr_o}, 32'd1);
    #1;
    reset_i = 1'b1;
    #1;
    chk_wr("arst", 1'b0, 5'd0, 32'd0);
    chk("arst_raw", {29'd0, raw_hazard_o}, 32'd0);
    chk("arst_ready", {31'd0, lu_ready_o}, 32'd1);
    step();
    reset_i = 1'b0;
    pipe_wr_i = 1'b0;
    step();
    chk("post_rst_empty", {31'd0, wr_o}, 32'd0);
    step();
    chk("post_rst_empty2", {31'd0, wr_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
